// File: rtl/slip_pkg.sv
// Shared SLIP constants, transmitter state encoding and escape helpers.
// Imported by both the transmitter and the receiver so framing bytes match.
package slip_pkg;

  localparam logic [7:0] CHAR_END     = 8'hC0;
  localparam logic [7:0] CHAR_ESC     = 8'hDB;
  localparam logic [7:0] CHAR_ESC_END = 8'hDC;
  localparam logic [7:0] CHAR_ESC_ESC = 8'hDD;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_ESC  = 2'd2,
    ST_EOF  = 2'd3
  } tx_state_e;

  function automatic logic is_special(input logic [7:0] b);
    return (b == CHAR_END) || (b == CHAR_ESC);
  endfunction

  // Second byte of the escape pair; non-special bytes pass through unchanged.
  function automatic logic [7:0] esc_suffix(input logic [7:0] b);
    if (b == CHAR_END) return CHAR_ESC_END;
    if (b == CHAR_ESC) return CHAR_ESC_ESC;
    return b;
  endfunction

endpackage

// File: rtl/slip_tx_if.sv
// Byte handshakes of the SLIP transmitter: raw input side and encoded link side.
// slave is the transmitter's view, master the view of whatever drives it.
interface slip_tx_if;
  logic [7:0] din;
  logic       din_rdy;
  logic       din_last;
  logic       din_ack;
  logic [7:0] dout;
  logic       dout_rdy;
  logic       dout_ack;
  logic       frame;

  modport slave (
    input  din, din_rdy, din_last, dout_ack,
    output din_ack, dout, dout_rdy, frame
  );

  modport master (
    output din, din_rdy, din_last, dout_ack,
    input  din_ack, dout, dout_rdy, frame
  );
endinterface

// File: rtl/slip_tx.sv
// SLIP transmitter: wraps raw frame bytes in 0xC0 delimiters and escapes
// 0xC0/0xDB, driving a single registered output slot with ready/ack handshake.
module slip_tx
  import slip_pkg::*;
#(
  parameter bit LEAD_END = 1'b1
) (
  input  logic     clk,
  input  logic     rst_n,
  slip_tx_if.slave tx
);

  // state | meaning
  // IDLE  | waiting for a frame; emits leading 0xC0 when LEAD_END=1
  // DATA  | consuming raw bytes, emitting plain bytes or the escape prefix
  // ESC   | emitting the latched escape suffix
  // EOF   | emitting the trailing 0xC0
  tx_state_e  state_q, state_d;
  logic [7:0] dout_q, dout_d;
  logic       dout_rdy_q, dout_rdy_d;
  logic       frame_q, frame_d;
  logic [7:0] pending_q, pending_d;
  logic       last_q, last_d;
  logic       din_ack;
  logic       slot_free;

  assign slot_free = !dout_rdy_q || tx.dout_ack;

  always_comb begin
    state_d    = state_q;
    dout_d     = dout_q;
    dout_rdy_d = dout_rdy_q && !tx.dout_ack;
    frame_d    = frame_q;
    pending_d  = pending_q;
    last_d     = last_q;
    din_ack    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tx.din_rdy) begin
          if (LEAD_END) begin
            if (slot_free) begin
              dout_d     = CHAR_END;
              dout_rdy_d = 1'b1;
              frame_d    = 1'b1;
              state_d    = ST_DATA;
            end
          end else begin
            frame_d = 1'b1;
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (tx.din_rdy && slot_free) begin
          din_ack    = 1'b1;
          last_d     = tx.din_last;
          dout_rdy_d = 1'b1;
          if (is_special(tx.din)) begin
            dout_d    = CHAR_ESC;
            pending_d = esc_suffix(tx.din);
            state_d   = ST_ESC;
          end else begin
            dout_d  = tx.din;
            state_d = tx.din_last ? ST_EOF : ST_DATA;
          end
        end
      end
      ST_ESC: begin
        if (slot_free) begin
          dout_d     = pending_q;
          dout_rdy_d = 1'b1;
          state_d    = last_q ? ST_EOF : ST_DATA;
        end
      end
      ST_EOF: begin
        if (slot_free) begin
          dout_d     = CHAR_END;
          dout_rdy_d = 1'b1;
          frame_d    = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset drops any partial frame outright; no trailing delimiter is sent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      dout_q     <= 8'h00;
      dout_rdy_q <= 1'b0;
      frame_q    <= 1'b0;
      pending_q  <= 8'h00;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dout_q     <= dout_d;
      dout_rdy_q <= dout_rdy_d;
      frame_q    <= frame_d;
      pending_q  <= pending_d;
      last_q     <= last_d;
    end
  end

  assign tx.din_ack  = din_ack;
  assign tx.dout     = dout_q;
  assign tx.dout_rdy = dout_rdy_q;
  assign tx.frame    = frame_q;

endmodule

// File: tb/tb_slip_tx.sv
// Directed bench for slip_tx: one instance with a leading delimiter, one without,
// encoded streams compared against hand-computed byte sequences.
module tb_slip_tx;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  slip_tx_if a_if ();
  slip_tx_if b_if ();

  slip_tx #(.LEAD_END(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .tx(a_if));
  slip_tx #(.LEAD_END(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .tx(b_if));

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] beats_a[$];
  logic [7:0] beats_b[$];
  logic [7:0] acked_a[$];
  int         frame_beats_a = 0;
  bit         stall = 1'b0;
  int         scnt = 0;
  logic [7:0] frm[8];
  logic [7:0] ex[16];
  logic [7:0] held;
  bit         held_v = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Downstream ack for instance A: always ready, or 5 stall cycles per loaded byte.
  always @(posedge clk) begin
    #1;
    if (!stall) begin
      a_if.dout_ack = 1'b1;
      scnt = 0;
    end else if (a_if.dout_rdy && scnt < 5) begin
      a_if.dout_ack = 1'b0;
      scnt++;
    end else begin
      a_if.dout_ack = a_if.dout_rdy;
      scnt = 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (a_if.din_ack) acked_a.push_back(a_if.din);
      if (a_if.dout_rdy && a_if.dout_ack) begin
        beats_a.push_back(a_if.dout);
        if (a_if.frame) frame_beats_a++;
        held_v = 1'b0;
      end else if (stall && a_if.dout_rdy) begin
        if (held_v) chk("stall_hold", {24'h0, a_if.dout}, {24'h0, held});
        chk("stall_no_din_ack", {31'h0, a_if.din_ack}, 32'h0);
        held   = a_if.dout;
        held_v = 1'b1;
      end
      if (b_if.dout_rdy && b_if.dout_ack) beats_b.push_back(b_if.dout);
    end
  end

  // Called at posedge+1; returns at posedge+1 after the last byte is acknowledged.
  task automatic send(input bit which, input int n);
    for (int i = 0; i < n; i++) begin
      bit got;
      got = 1'b0;
      if (which) begin
        b_if.din = frm[i]; b_if.din_last = (i == n - 1); b_if.din_rdy = 1'b1;
      end else begin
        a_if.din = frm[i]; a_if.din_last = (i == n - 1); a_if.din_rdy = 1'b1;
      end
      for (int c = 0; c < 200 && !got; c++) begin
        @(negedge clk);
        got = which ? b_if.din_ack : a_if.din_ack;
        @(posedge clk); #1;
      end
      if (!got) chk("din_ack_timeout", {31'h0, got}, 32'h1);
    end
    if (which) begin b_if.din_rdy = 1'b0; b_if.din_last = 1'b0; end
    else begin a_if.din_rdy = 1'b0; a_if.din_last = 1'b0; end
  endtask

  task automatic wait_done(input bit which);
    logic [1:0] st;
    st = 2'b11;
    for (int c = 0; c < 300 && st != 2'b00; c++) begin
      @(negedge clk);
      st = which ? {b_if.dout_rdy, b_if.frame} : {a_if.dout_rdy, a_if.frame};
    end
    chk("frame_done", {30'h0, st}, 32'h0);
    @(posedge clk); #1;
  endtask

  task automatic check_q(input string tag, input bit which, input int n);
    logic [7:0] q[$];
    q = which ? beats_b : beats_a;
    chk({tag, "_len"}, q.size(), n);
    for (int i = 0; i < n && i < q.size(); i++)
      chk($sformatf("%s_beat%0d", tag, i), {24'h0, q[i]}, {24'h0, ex[i]});
  endtask

  task automatic clear_logs();
    beats_a.delete(); beats_b.delete(); acked_a.delete();
    frame_beats_a = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    a_if.din = 8'h00; a_if.din_rdy = 1'b1; a_if.din_last = 1'b0; a_if.dout_ack = 1'b1;
    b_if.din = 8'h00; b_if.din_rdy = 1'b0; b_if.din_last = 1'b0; b_if.dout_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", {24'h0, a_if.dout}, 32'h0);
    chk("rst_dout_rdy", {31'h0, a_if.dout_rdy}, 32'h0);
    chk("rst_frame", {31'h0, a_if.frame}, 32'h0);
    chk("rst_din_ack", {31'h0, a_if.din_ack}, 32'h0);
    a_if.din_rdy = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    clear_logs();
    frm = '{8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send(1'b0, 2);
    wait_done(1'b0);
    ex = '{0:8'hC0, 1:8'h01, 2:8'h02, 3:8'hC0, default:8'h00};
    check_q("plain", 1'b0, 4);
    chk("plain_din_acks", acked_a.size(), 2);
    chk("plain_frame_beats", frame_beats_a, 3);

    clear_logs();
    frm = '{8'hC0, 8'hDB, 8'h7E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send(1'b0, 3);
    wait_done(1'b0);
    ex = '{0:8'hC0, 1:8'hDB, 2:8'hDC, 3:8'hDB, 4:8'hDD, 5:8'h7E, 6:8'hC0, default:8'h00};
    check_q("esc", 1'b0, 7);
    chk("esc_din_acks", acked_a.size(), 3);
    if (acked_a.size() == 3) begin
      chk("esc_ack0", {24'h0, acked_a[0]}, 32'hC0);
      chk("esc_ack1", {24'h0, acked_a[1]}, 32'hDB);
      chk("esc_ack2", {24'h0, acked_a[2]}, 32'h7E);
    end

    clear_logs();
    frm = '{8'hC0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send(1'b0, 1);
    wait_done(1'b0);
    ex = '{0:8'hC0, 1:8'hDB, 2:8'hDC, 3:8'hC0, default:8'h00};
    check_q("esc_last", 1'b0, 4);

    clear_logs();
    stall = 1'b1;
    frm = '{8'h55, 8'hAA, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send(1'b0, 2);
    wait_done(1'b0);
    stall = 1'b0;
    ex = '{0:8'hC0, 1:8'h55, 2:8'hAA, 3:8'hC0, default:8'h00};
    check_q("stall", 1'b0, 4);
    chk("stall_din_acks", acked_a.size(), 2);
    @(posedge clk); #1;

    clear_logs();
    frm = '{8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send(1'b1, 1);
    frm = '{8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send(1'b1, 1);
    wait_done(1'b1);
    ex = '{0:8'h11, 1:8'hC0, 2:8'h22, 3:8'hC0, default:8'h00};
    check_q("nolead", 1'b1, 4);

    // Mid-frame reset after the leading C0 and first data byte have gone out.
    clear_logs();
    a_if.din = 8'h01; a_if.din_last = 1'b0; a_if.din_rdy = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("latency_dout", {24'h0, a_if.dout}, 32'h01);
    chk("latency_rdy", {31'h0, a_if.dout_rdy}, 32'h1);
    a_if.din = 8'h02;
    @(negedge clk); #2;
    chk("pre_rst_beats", beats_a.size(), 2);
    rst_n = 1'b0;
    a_if.din_rdy = 1'b0;
    #1;
    chk("mid_rst_dout", {24'h0, a_if.dout}, 32'h0);
    chk("mid_rst_rdy", {31'h0, a_if.dout_rdy}, 32'h0);
    chk("mid_rst_frame", {31'h0, a_if.frame}, 32'h0);
    chk("mid_rst_din_ack", {31'h0, a_if.din_ack}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    clear_logs();
    frm = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send(1'b0, 1);
    wait_done(1'b0);
    ex = '{0:8'hC0, 1:8'h04, 2:8'hC0, default:8'h00};
    check_q("post_rst", 1'b0, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
